// File: rtl/pipe_stage_reg.sv
`default_nettype none
// ============================================================================
// Module      : pipe_stage_reg
// Description : Inter-stage pipeline register with valid/ready handshake,
//               optional 2-entry skid buffer, stall, flush and stall counter.
// Revision    : 1.0 - initial release
// ============================================================================
module pipe_stage_reg #(
    parameter int unsigned       DATA_W      = 96,
    parameter int unsigned       CTRL_W      = 10,
    parameter logic [CTRL_W-1:0] BUBBLE_CTRL = {CTRL_W{1'b0}},
    parameter int unsigned       SKID        = 1,
    parameter int unsigned       CNT_W       = 16
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              valid_i,
    output logic              ready_o,
    input  logic [CTRL_W-1:0] ctrl_i,
    input  logic [DATA_W-1:0] data_i,
    input  logic              stall_i,
    input  logic              flush_i,
    output logic              valid_o,
    input  logic              ready_i,
    output logic [CTRL_W-1:0] ctrl_o,
    output logic [DATA_W-1:0] data_o,
    output logic [CNT_W-1:0]  stall_cnt_o
);

    logic              r_valid;
    logic [CTRL_W-1:0] r_ctrl;
    logic [DATA_W-1:0] r_data;
    logic [CNT_W-1:0]  r_cnt;

    assign valid_o     = r_valid;
    assign ctrl_o      = r_ctrl;
    assign data_o      = r_data;
    assign stall_cnt_o = r_cnt;

    // Counts stalled cycles while holding a live beat; flush does not clear it.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_cnt <= '0;
        end else if (stall_i && r_valid && !(&r_cnt)) begin
            r_cnt <= r_cnt + CNT_W'(1);
        end
    end

    generate
        if (SKID != 0) begin : g_skid
            typedef enum logic [1:0] {
                ST_EMPTY = 2'd0,
                ST_ONE   = 2'd1,
                ST_TWO   = 2'd2
            } state_t;

            state_t            r_state;
            logic              r_ready;
            logic [CTRL_W-1:0] r_skid_ctrl;
            logic [DATA_W-1:0] r_skid_data;
            logic              w_in_xfer;
            logic              w_out_xfer;

            assign ready_o    = r_ready;
            assign w_in_xfer  = valid_i & r_ready & ~stall_i & ~flush_i;
            assign w_out_xfer = r_valid & ready_i & ~stall_i & ~flush_i;

            always_ff @(posedge clk_i) begin
                if (rst_i) begin
                    r_state     <= ST_EMPTY;
                    r_valid     <= 1'b0;
                    r_ctrl      <= BUBBLE_CTRL;
                    r_data      <= '0;
                    r_skid_ctrl <= '0;
                    r_skid_data <= '0;
                    r_ready     <= 1'b1;
                end else if (flush_i) begin
                    // data_o deliberately left untouched; it is don't-care when empty
                    r_state     <= ST_EMPTY;
                    r_valid     <= 1'b0;
                    r_ctrl      <= BUBBLE_CTRL;
                    r_skid_ctrl <= '0;
                    r_skid_data <= '0;
                    r_ready     <= 1'b1;
                end else if (!stall_i) begin
                    case (r_state)
                        ST_EMPTY: begin
                            if (w_in_xfer) begin
                                r_state <= ST_ONE;
                                r_valid <= 1'b1;
                                r_ctrl  <= ctrl_i;
                                r_data  <= data_i;
                            end
                        end
                        ST_ONE: begin
                            if (w_in_xfer && w_out_xfer) begin
                                r_ctrl <= ctrl_i;
                                r_data <= data_i;
                            end else if (w_in_xfer) begin
                                r_state     <= ST_TWO;
                                r_skid_ctrl <= ctrl_i;
                                r_skid_data <= data_i;
                                r_ready     <= 1'b0;
                            end else if (w_out_xfer) begin
                                r_state <= ST_EMPTY;
                                r_valid <= 1'b0;
                                r_ctrl  <= BUBBLE_CTRL;
                            end
                        end
                        ST_TWO: begin
                            if (w_out_xfer) begin
                                r_state <= ST_ONE;
                                r_ctrl  <= r_skid_ctrl;
                                r_data  <= r_skid_data;
                                r_ready <= 1'b1;
                            end
                        end
                        default: begin
                            r_state <= ST_EMPTY;
                            r_valid <= 1'b0;
                            r_ctrl  <= BUBBLE_CTRL;
                            r_ready <= 1'b1;
                        end
                    endcase
                end
            end
        end else begin : g_noskid
            logic w_in_xfer;
            logic w_out_xfer;

            // Downstream acceptance this cycle frees the register for a new beat.
            assign ready_o    = ~r_valid | (ready_i & ~stall_i);
            assign w_in_xfer  = valid_i & ready_o & ~stall_i & ~flush_i;
            assign w_out_xfer = r_valid & ready_i & ~stall_i & ~flush_i;

            always_ff @(posedge clk_i) begin
                if (rst_i) begin
                    r_valid <= 1'b0;
                    r_ctrl  <= BUBBLE_CTRL;
                    r_data  <= '0;
                end else if (flush_i) begin
                    r_valid <= 1'b0;
                    r_ctrl  <= BUBBLE_CTRL;
                end else if (w_in_xfer) begin
                    r_valid <= 1'b1;
                    r_ctrl  <= ctrl_i;
                    r_data  <= data_i;
                end else if (w_out_xfer) begin
                    r_valid <= 1'b0;
                    r_ctrl  <= BUBBLE_CTRL;
                end
            end
        end
    endgenerate

endmodule
`default_nettype wire

// File: tb/tb_pipe_stage_reg.sv
`default_nettype none
// Testbench for pipe_stage_reg: per-cycle vector table plus a scoreboard of
// accepted beats; a second SKID=0, CNT_W=4 instance covers counter saturation.
module tb_pipe_stage_reg;

    localparam int DW = 96;
    localparam int CW = 10;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          valid_in = 1'b0;
    logic          ready_in = 1'b0;
    logic          stall = 1'b0;
    logic          flush = 1'b0;
    logic [CW-1:0] ctrl_in = '0;
    logic [DW-1:0] data_in = '0;

    logic          ready_o, valid_o;
    logic [CW-1:0] ctrl_o;
    logic [DW-1:0] data_o;
    logic [15:0]   cnt_o;

    logic          ready4, valid4;
    logic [CW-1:0] ctrl4;
    logic [DW-1:0] data4;
    logic [3:0]    cnt4;

    always #5 clk = ~clk;

    pipe_stage_reg #(.DATA_W(DW), .CTRL_W(CW), .SKID(1), .CNT_W(16)) u_dut (
        .clk_i(clk), .rst_i(rst), .valid_i(valid_in), .ready_o(ready_o),
        .ctrl_i(ctrl_in), .data_i(data_in), .stall_i(stall), .flush_i(flush),
        .valid_o(valid_o), .ready_i(ready_in), .ctrl_o(ctrl_o), .data_o(data_o),
        .stall_cnt_o(cnt_o)
    );

    pipe_stage_reg #(.DATA_W(DW), .CTRL_W(CW), .SKID(0), .CNT_W(4)) u_dut4 (
        .clk_i(clk), .rst_i(rst), .valid_i(valid_in), .ready_o(ready4),
        .ctrl_i(ctrl_in), .data_i(data_in), .stall_i(stall), .flush_i(flush),
        .valid_o(valid4), .ready_i(ready_in), .ctrl_o(ctrl4), .data_o(data4),
        .stall_cnt_o(cnt4)
    );

    typedef struct {
        logic        v, r, st, fl, rs;
        logic [7:0]  d;
        logic        ev, er;
        logic [15:0] ecnt;
    } vec_t;

    vec_t                 vq[$];
    logic [CW+DW-1:0]     sb[$];
    int                   n_pass = 0;
    int                   n_total = 0;

    task automatic check(input string nm, input logic [127:0] act, input logic [127:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    endtask

    task automatic add(input logic v, r, st, fl, rs, input logic [7:0] d,
                       input logic ev, er, input int ecnt);
        vec_t t;
        t.v = v; t.r = r; t.st = st; t.fl = fl; t.rs = rs; t.d = d;
        t.ev = ev; t.er = er; t.ecnt = 16'(ecnt);
        vq.push_back(t);
    endtask

    // Scores the output transfer due on the coming edge, records any accepted beat, then advances.
    task automatic tick();
        logic [CW+DW-1:0] e;
        if (!rst && !flush && !stall && valid_o === 1'b1 && ready_in) begin
            if (sb.size() == 0) begin
                check("sb_unexpected_output", 128'(data_o), 128'hDEAD);
            end else begin
                e = sb.pop_front();
                check("sb_ctrl", 128'(ctrl_o), 128'(e[CW+DW-1:DW]));
                check("sb_data", 128'(data_o), 128'(e[DW-1:0]));
            end
        end
        if (rst || flush) sb.delete();
        else if (!stall && valid_in && ready_o === 1'b1) sb.push_back({ctrl_in, data_in});
        @(posedge clk);
        #1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        //   v  r  st fl rs  d      ev er cnt
        add(0, 0, 0, 0, 1, 8'h00, 0, 1, 0);   // reset
        add(1, 1, 0, 0, 0, 8'h11, 1, 1, 0);   // stream of 4
        add(1, 1, 0, 0, 0, 8'h22, 1, 1, 0);
        add(1, 1, 0, 0, 0, 8'h33, 1, 1, 0);
        add(1, 1, 0, 0, 0, 8'h44, 1, 1, 0);
        add(0, 1, 0, 0, 0, 8'h00, 0, 1, 0);
        add(1, 0, 0, 0, 0, 8'hA1, 1, 1, 0);   // backpressure into TWO
        add(1, 0, 0, 0, 0, 8'hA2, 1, 0, 0);
        add(1, 0, 0, 0, 0, 8'hA3, 1, 0, 0);
        add(0, 1, 0, 0, 0, 8'h00, 1, 1, 0);
        add(0, 1, 0, 0, 0, 8'h00, 0, 1, 0);
        add(1, 1, 0, 0, 0, 8'hB1, 1, 1, 0);   // 5-cycle stall
        for (int i = 1; i <= 5; i++) add(1, 1, 1, 0, 0, 8'hB2, 1, 1, i);
        add(1, 1, 0, 0, 0, 8'hB2, 1, 1, 5);
        add(1, 1, 0, 0, 0, 8'hB3, 1, 1, 5);
        add(0, 1, 0, 0, 0, 8'h00, 0, 1, 5);
        add(1, 0, 0, 0, 0, 8'hC1, 1, 1, 5);   // flush in TWO
        add(1, 0, 0, 0, 0, 8'hC2, 1, 0, 5);
        add(1, 1, 0, 1, 0, 8'hC3, 0, 1, 5);
        add(0, 1, 0, 0, 0, 8'h00, 0, 1, 5);
        add(1, 0, 0, 0, 0, 8'hD1, 1, 1, 5);   // flush + stall
        add(1, 0, 1, 1, 0, 8'hD2, 0, 1, 6);
        add(0, 0, 1, 0, 0, 8'h00, 0, 1, 6);
        add(1, 0, 0, 0, 0, 8'hE1, 1, 1, 6);   // reset during stall in TWO
        add(1, 0, 0, 0, 0, 8'hE2, 1, 0, 6);
        add(1, 0, 1, 0, 0, 8'hE3, 1, 0, 7);
        add(1, 0, 1, 0, 1, 8'hE3, 0, 1, 0);
        add(0, 0, 0, 0, 0, 8'h00, 0, 1, 0);
        add(1, 1, 0, 0, 0, 8'hF1, 1, 1, 0);
        add(0, 1, 0, 0, 0, 8'h00, 0, 1, 0);

        foreach (vq[i]) begin
            valid_in = vq[i].v;
            ready_in = vq[i].r;
            stall    = vq[i].st;
            flush    = vq[i].fl;
            rst      = vq[i].rs;
            data_in  = DW'(vq[i].d);
            ctrl_in  = vq[i].fl ? 10'h3FF : {2'b01, vq[i].d};
            tick();
            check($sformatf("valid_o[%0d]", i), 128'(valid_o), 128'(vq[i].ev));
            check($sformatf("ready_o[%0d]", i), 128'(ready_o), 128'(vq[i].er));
            check($sformatf("stall_cnt[%0d]", i), 128'(cnt_o), 128'(vq[i].ecnt));
            if (!vq[i].ev) check($sformatf("bubble_ctrl[%0d]", i), 128'(ctrl_o), 128'(0));
        end

        // Counter saturation on the 4-bit, SKID=0 instance.
        valid_in = 1'b1; ready_in = 1'b0; stall = 1'b0; flush = 1'b0; rst = 1'b0;
        data_in = DW'(8'h55); ctrl_in = 10'h155;
        tick();
        check("sat_valid4", 128'(valid4), 128'(1));
        valid_in = 1'b0; ready_in = 1'b1; stall = 1'b1;
        #1;
        check("noskid_ready_stalled", 128'(ready4), 128'(0));
        for (int i = 1; i <= 20; i++) begin
            tick();
            if (i == 15) check("sat_cnt4_at15", 128'(cnt4), 128'(15));
        end
        check("sat_cnt4_held", 128'(cnt4), 128'(15));
        check("cnt16_after20", 128'(cnt_o), 128'(20));
        check("sat_valid4_held", 128'(valid4), 128'(1));
        stall = 1'b0;
        #1;
        check("noskid_ready_comb", 128'(ready4), 128'(1));
        check("noskid_data", 128'(data4), 128'(8'h55));
        tick();
        check("noskid_drained", 128'(valid4), 128'(0));
        check("sb_empty_at_end", 128'(sb.size()), 128'(0));

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/pipe_stage_reg.md
Name: pipe_stage_reg

Overview:
Parametrised inter-stage pipeline register and successor to the fixed-field stage latches. It carries a generic control bundle and a generic data bundle between two pipeline stages.
- Adds a valid/ready handshake with an optional 2-entry skid buffer, so upstream ready is registered.
- Adds a global memory stall (freeze), a hazard flush that inserts a bubble, and a saturating stall-cycle counter for performance visibility.
- Sits between any two stages (IF/ID, ID/EX, EX/MEM, MEM/WB) of the pipelined CPU with cache.

Parameters:
DATA_W, 96, width of data bundle (operands, immediate, register addresses, funct).
CTRL_W, 10, width of control bundle (ALUOp, ALUSrc, RegWrite, MemWrite, MemRead, MemtoReg, Branch, ...).
BUBBLE_CTRL, {CTRL_W{1'b0}}, control value presented whenever the stage holds no valid instruction.
SKID, 1, 1 = 2-entry skid buffer with registered ready_o; 0 = single register with combinational ready_o.
CNT_W, 16, width of stall-cycle counter.

Ports:
clk_i  in  1  clock, all state updates on rising edge.
rst_i  in  1  reset, synchronous, active-high.
valid_i  in  1  upstream beat valid.
ready_o  out  1  stage can accept a beat.
ctrl_i  in  CTRL_W  upstream control bundle.
data_i  in  DATA_W  upstream data bundle.
stall_i  in  1  global memory stall; freezes all stage state.
flush_i  in  1  hazard/branch flush; empties stage and inserts a bubble.
valid_o  out  1  downstream beat valid.
ready_i  in  1  downstream accepts beat.
ctrl_o  out  CTRL_W  registered control bundle.
data_o  out  DATA_W  registered data bundle.
stall_cnt_o  out  CNT_W  saturating count of stalled cycles while valid_o=1.

Behaviour:
- Clock and reset: one clock, clk_i. Reset rst_i is synchronous and active-high. Priority on each edge: rst_i > flush_i > stall_i > normal operation.
- Reset values: valid_o=0, ctrl_o=BUBBLE_CTRL, data_o=0, skid entry empty with skid data=0, ready_o=1, stall_cnt_o=0.
- Definitions:
  - in_xfer = valid_i & ready_o & ~stall_i & ~flush_i
  - out_xfer = valid_o & ready_i & ~stall_i & ~flush_i
- Invariant: ctrl_o == BUBBLE_CTRL whenever valid_o==0. This guarantees no RegWrite/MemWrite reaches downstream from an empty stage.
- SKID=1 state machine. States: EMPTY (valid_o=0), ONE (output register full, skid empty), TWO (both full).
  - EMPTY: in_xfer -> ONE, output register <= beat. Otherwise stay.
  - ONE, in_xfer & out_xfer -> ONE, output register <= new beat.
  - ONE, in_xfer & ~out_xfer -> TWO, skid <= beat.
  - ONE, ~in_xfer & out_xfer -> EMPTY, ctrl_o <= BUBBLE_CTRL.
  - ONE, neither transfer -> hold.
  - TWO: ready_o=0, so no input is accepted. out_xfer -> ONE, output register <= skid contents. Otherwise hold.
  - ready_o is registered and equals "skid empty" (1 in EMPTY and ONE, 0 in TWO).
- SKID=0:
  - ready_o = ~valid_o | (ready_i & ~stall_i), combinational; TWO is unreachable.
  - Latency: beat accepted on edge N appears on valid_o/ctrl_o/data_o after edge N, i.e. 1 cycle.
- Ordering: beats leave in acceptance order; no duplication and no loss except on flush.
- stall_i=1 (without flush): every register holds its value, including valid_o, ctrl_o, data_o, skid and ready_o. No transfer occurs in either direction regardless of valid_i/ready_i. Upstream and downstream must qualify handshakes with stall_i.
- flush_i=1 (overrides stall_i):
  - Next state is EMPTY: valid_o=0, ctrl_o=BUBBLE_CTRL, skid cleared, ready_o=1.
  - data_o holds its previous value (don't-care).
  - A beat presented in the same cycle is discarded.
- stall_cnt_o: +1 each edge with stall_i=1 & valid_o=1 & ~rst_i. Saturates at all ones with no wrap. Cleared only by reset; flush does not clear it.
- Reset asserted mid-operation (including in TWO or during stall): next edge reaches the reset values. In-flight beats are lost.

Test Plan:
1. Reset then a stream of 4 beats with ready_i=1, data 0x11..0x44 -> valid_o rises 1 cycle after each accept, outputs 0x11, 0x22, 0x33, 0x44 in order, ready_o stays 1.
2. SKID=1 backpressure: accept 0xA1, drop ready_i, present 0xA2 -> state TWO, ready_o=0 on the following cycle. Raise ready_i -> 0xA1 then 0xA2 delivered, ready_o returns to 1, no loss.
3. stall_i held 5 cycles with valid_o=1 and valid_i=1, ready_i=1 -> outputs frozen, no beat accepted or delivered, stall_cnt_o increments by 5. Release -> stream resumes with correct order.
4. flush_i pulse in TWO while valid_i=1, ctrl_i=0x3FF -> next cycle valid_o=0, ctrl_o=BUBBLE_CTRL (0x000), ready_o=1, incoming beat absent from the output.
5. flush_i and stall_i asserted together -> flush wins: stage empties. Separately, rst_i asserted during stall -> all outputs at reset values next edge, stall_cnt_o=0.
6. CNT_W=4, stall 20 cycles with valid_o=1 -> stall_cnt_o saturates at 15 and does not wrap.
